// File: rtl/scan_disp_pkg.sv
// Shared seven-segment constants (active-low, gfedcba) and display-mode encodings.
// Pure definitions: no latency, no flow control.
package scan_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        MODE_NUM   = 2'd0,
        MODE_MSG   = 2'd1,
        MODE_BEAT  = 2'd2,
        MODE_BLANK = 2'd3
    } mode_e;

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low gfedcba pattern; codes 10-15 show a dash.
// Purely combinational, zero latency, no flow control.
module seg7_decode
    import scan_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/scan_display_ctrl.sv
// Multiplexed 7-segment scanner with per-frame shadowed inputs and a guard cycle per digit.
// Outputs registered one cycle after the cnt/idx state; free-running, no backpressure.
module scan_display_ctrl
    import scan_disp_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 16,
    parameter int BLANK_LEADING = 1
)
(
    input  logic                    fclk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [7*NUM_DIGITS-1:0] msg,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [1:0]              mode,
    input  logic                    bclk,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segOut,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] dig_s_q, dig_s_d;
    logic [7*NUM_DIGITS-1:0] msg_s_q, msg_s_d;
    logic [NUM_DIGITS-1:0]   dpm_s_q, dpm_s_d;
    mode_e                   mode_s_q, mode_s_d;
    logic                    beat_s_q, beat_s_d;
    logic                    bsync1_q, bsync1_d;
    logic                    bsync2_q, bsync2_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_tick_q, frame_tick_d;

    logic       cnt_wrap, frame_wrap, guard, use_num, upper_zero, lead_zero;
    logic [3:0] cur_nib;
    logic [6:0] cur_msg, dec_seg, num_seg;
    logic       cur_dpm;

    // Scan sequencing, synchroniser and frame-boundary shadow capture.
    always_comb begin
        cnt_wrap   = (cnt_q == CNT_LAST);
        frame_wrap = cnt_wrap && (idx_q == IDX_LAST);

        cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        bsync1_d = bclk;
        bsync2_d = bsync1_q;

        dig_s_d  = dig_s_q;
        msg_s_d  = msg_s_q;
        dpm_s_d  = dpm_s_q;
        mode_s_d = mode_s_q;
        beat_s_d = beat_s_q;
        if (frame_wrap) begin
            dig_s_d  = digits;
            msg_s_d  = msg;
            dpm_s_d  = dp_mask;
            mode_s_d = mode_e'(mode);
            beat_s_d = bsync2_q;
        end

        frame_tick_d = frame_wrap;
    end

    // Select the current digit's shadowed data; upper_zero walks down from the MSD.
    always_comb begin
        cur_nib    = '0;
        cur_msg    = SEG_BLANK;
        cur_dpm    = 1'b0;
        lead_zero  = 1'b0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (dig_s_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = dig_s_q[4*i +: 4];
                cur_msg   = msg_s_q[7*i +: 7];
                cur_dpm   = dpm_s_q[i];
                lead_zero = upper_zero && (i != 0);
            end
        end
    end

    seg7_decode u_dec (
        .bcd (cur_nib),
        .seg (dec_seg)
    );

    always_comb begin
        guard   = (cnt_q == '0);
        use_num = (mode_s_q == MODE_NUM) || ((mode_s_q == MODE_BEAT) && beat_s_q);
        num_seg = ((BLANK_LEADING != 0) && lead_zero) ? SEG_BLANK : dec_seg;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_d[i] = guard || (idx_q != IDX_W'(i));
        end

        seg_d = use_num ? num_seg : cur_msg;
        if (guard || (mode_s_q == MODE_BLANK)) begin
            seg_d = SEG_BLANK;
        end

        dp_d = (mode_s_q == MODE_BLANK) ? 1'b1 : ~cur_dpm;
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            dig_s_q      <= '0;
            msg_s_q      <= '0;
            dpm_s_q      <= '0;
            mode_s_q     <= MODE_NUM;
            beat_s_q     <= 1'b0;
            bsync1_q     <= 1'b0;
            bsync2_q     <= 1'b0;
            anode_q      <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dig_s_q      <= dig_s_d;
            msg_s_q      <= msg_s_d;
            dpm_s_q      <= dpm_s_d;
            mode_s_q     <= mode_s_d;
            beat_s_q     <= beat_s_d;
            bsync1_q     <= bsync1_d;
            bsync2_q     <= bsync2_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode      = anode_q;
    assign segOut     = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl (4 digits, SCAN_DIV=4) with and without zero blanking.
// Checks every output cycle of each frame against hand-derived segment patterns.
module tb_scan_display_ctrl;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;
    localparam logic [6:0] CR = 7'b0101111, CE = 7'b0000110, CC = 7'b1000110;
    localparam logic [27:0] MSG   = {CR, CE, CC, SD};
    localparam logic [27:0] BLANK = {SB, SB, SB, SB};

    logic        fclk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [27:0] msg;
    logic [3:0]  dp_mask;
    logic [1:0]  mode;
    logic        bclk;
    logic [3:0]  anode, anode_nb;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb, ft, ft_nb;

    int errors = 0;
    int checks = 0;

    logic [15:0] nxt_digits;
    logic [1:0]  nxt_mode;
    logic        nxt_bclk;

    always #5 fclk = ~fclk;

    scan_display_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LEADING(1)) u_dut (
        .fclk(fclk), .rst(rst), .digits(digits), .msg(msg), .dp_mask(dp_mask),
        .mode(mode), .bclk(bclk), .anode(anode), .segOut(seg), .dp(dp), .frame_tick(ft)
    );

    scan_display_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LEADING(0)) u_nb (
        .fclk(fclk), .rst(rst), .digits(digits), .msg(msg), .dp_mask(dp_mask),
        .mode(mode), .bclk(bclk), .anode(anode_nb), .segOut(seg_nb), .dp(dp_nb),
        .frame_tick(ft_nb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Output cycle j (1..16) after a frame_tick shows digit (j-1)/4, dwell slot (j-1)%4.
    task automatic check_frame(input string name, input logic [27:0] es,
                               input logic [27:0] es_nb, input logic [3:0] edp,
                               input int chg_at);
        for (int j = 1; j <= 16; j++) begin
            int d, c;
            logic [3:0] ea;
            logic [6:0] e_seg, e_seg_nb;
            @(negedge fclk);
            d = (j - 1) / 4;
            c = (j - 1) % 4;
            ea       = (c == 0) ? 4'hF : ~(4'b0001 << d);
            e_seg    = (c == 0) ? SB : es[7*d +: 7];
            e_seg_nb = (c == 0) ? SB : es_nb[7*d +: 7];
            chk($sformatf("%s anode j=%0d", name, j), 32'(anode), 32'(ea));
            chk($sformatf("%s seg j=%0d", name, j), 32'(seg), 32'(e_seg));
            chk($sformatf("%s dp j=%0d", name, j), 32'(dp), 32'(edp[d]));
            chk($sformatf("%s frame_tick j=%0d", name, j), 32'(ft), 32'(j == 16));
            chk($sformatf("%s nb_anode j=%0d", name, j), 32'(anode_nb), 32'(ea));
            chk($sformatf("%s nb_seg j=%0d", name, j), 32'(seg_nb), 32'(e_seg_nb));
            chk($sformatf("%s nb_dp j=%0d", name, j), 32'(dp_nb), 32'(edp[d]));
            if (j == chg_at) begin
                digits = nxt_digits;
                mode   = nxt_mode;
                bclk   = nxt_bclk;
            end
        end
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge fclk);
            n++;
        end while (ft !== 1'b1 && n < 40);
        chk({name, " tick_timeout"}, 32'(ft), 32'd1);
    endtask

    task automatic run_vec(input string name, input logic [15:0] d, input logic [1:0] md,
                           input logic [3:0] dpm, input logic b, input logic [27:0] es,
                           input logic [27:0] es_nb, input logic [3:0] edp, input int chg_at);
        digits  = d;
        mode    = md;
        dp_mask = dpm;
        bclk    = b;
        wait_tick(name);
        check_frame(name, es, es_nb, edp, chg_at);
    endtask

    initial begin
        rst     = 1'b1;
        digits  = 16'h0120;
        msg     = MSG;
        dp_mask = 4'h0;
        mode    = 2'd0;
        bclk    = 1'b0;
        nxt_digits = 16'h0000;
        nxt_mode   = 2'd0;
        nxt_bclk   = 1'b0;

        repeat (3) @(negedge fclk);
        chk("rst anode", 32'(anode), 32'hF);
        chk("rst seg", 32'(seg), 32'(SB));
        chk("rst dp", 32'(dp), 32'd1);
        chk("rst frame_tick", 32'(ft), 32'd0);

        // Shadows are zero for the first frame; its tick lands 16 cycles after release.
        rst = 1'b0;
        check_frame("first_frame", {SB, SB, SB, S0}, {S0, S0, S0, S0}, 4'hF, 0);
        check_frame("num_0120", {SB, S1, S2, S0}, {S0, S1, S2, S0}, 4'hF, 0);

        run_vec("num_0000", 16'h0000, 2'd0, 4'h0, 1'b0, {SB, SB, SB, S0}, {S0, S0, S0, S0}, 4'hF, 0);
        run_vec("num_000B", 16'h000B, 2'd0, 4'b0001, 1'b0, {SB, SB, SB, SD}, {S0, S0, S0, SD}, 4'b1110, 0);
        run_vec("num_9876", 16'h9876, 2'd0, 4'b1010, 1'b0, {S9, S8, S7, S6}, {S9, S8, S7, S6}, 4'b0101, 0);
        run_vec("num_5432", 16'h5432, 2'd0, 4'h0, 1'b0, {S5, S4, S3, S2}, {S5, S4, S3, S2}, 4'hF, 0);
        run_vec("num_F0A1", 16'hF0A1, 2'd0, 4'h0, 1'b0, {SD, S0, SD, S1}, {SD, S0, SD, S1}, 4'hF, 0);
        run_vec("num_0B00", 16'h0B00, 2'd0, 4'b0100, 1'b0, {SB, SD, S0, S0}, {S0, SD, S0, S0}, 4'b1011, 0);
        run_vec("msg", 16'h0000, 2'd1, 4'h0, 1'b0, MSG, MSG, 4'hF, 0);
        run_vec("blank", 16'h1234, 2'd3, 4'hF, 1'b0, BLANK, BLANK, 4'hF, 0);

        // Beat mode: bclk flips mid-frame; the switch shows only from the next frame.
        nxt_digits = 16'h0120; nxt_mode = 2'd2; nxt_bclk = 1'b0;
        run_vec("beat_num0", 16'h0120, 2'd2, 4'h0, 1'b1, {SB, S1, S2, S0}, {S0, S1, S2, S0}, 4'hF, 0);
        check_frame("beat_num1", {SB, S1, S2, S0}, {S0, S1, S2, S0}, 4'hF, 0);
        check_frame("beat_num2", {SB, S1, S2, S0}, {S0, S1, S2, S0}, 4'hF, 9);
        check_frame("beat_msg0", MSG, MSG, 4'hF, 0);
        check_frame("beat_msg1", MSG, MSG, 4'hF, 0);
        nxt_bclk = 1'b1;
        check_frame("beat_msg2", MSG, MSG, 4'hF, 9);
        check_frame("beat_num3", {SB, S1, S2, S0}, {S0, S1, S2, S0}, 4'hF, 0);

        // digits change at idx=2 of a frame, then a mode change mid-frame.
        nxt_digits = 16'h5678; nxt_mode = 2'd0; nxt_bclk = 1'b1;
        run_vec("tear_1234", 16'h1234, 2'd0, 4'h0, 1'b1, {S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'hF, 9);
        nxt_mode = 2'd3;
        check_frame("next_5678", {S5, S6, S7, S8}, {S5, S6, S7, S8}, 4'hF, 6);
        check_frame("mode_chg_blank", BLANK, BLANK, 4'hF, 0);

        // Asynchronous reset at idx=1, cnt=2.
        digits = 16'h1234;
        mode   = 2'd0;
        wait_tick("pre_reset");
        repeat (6) @(negedge fclk);
        chk("pre_reset anode", 32'(anode), 32'b1101);
        chk("pre_reset seg", 32'(seg), 32'(S3));
        #2 rst = 1'b1;
        #1;
        chk("async_rst anode", 32'(anode), 32'hF);
        chk("async_rst seg", 32'(seg), 32'(SB));
        chk("async_rst dp", 32'(dp), 32'd1);
        chk("async_rst frame_tick", 32'(ft), 32'd0);
        chk("async_rst nb_anode", 32'(anode_nb), 32'hF);
        repeat (2) @(negedge fclk);
        rst = 1'b0;
        check_frame("restart_frame", {SB, SB, SB, S0}, {S0, S0, S0, S0}, 4'hF, 0);
        check_frame("restart_1234", {S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'hF, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_display_ctrl.md
SCAN_DISPLAY_CTRL -- requirements
Module: scan_display_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits (legal 2..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 16, giving the fclk cycles each digit dwells for (legal 4..65535).
REQ-003 The block SHALL have parameter BLANK_LEADING, default 1; when 1, leading-zero suppression is enabled.
REQ-004 Ports SHALL be:
- fclk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- digits  in  4*NUM_DIGITS  BCD value; nibble i is digit i, digit 0 is the rightmost (LSD).
- msg  in  7*NUM_DIGITS  raw active-low segment patterns for message mode; slice i is digit i.
- dp_mask  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- mode  in  2  display mode: 0 number, 1 message, 2 beat-alternate, 3 blank.
- bclk  in  1  beat level from the metronome; asynchronous to fclk.
- anode  out  NUM_DIGITS  active-low digit enables.
- segOut  out  7  active-low cathodes, gfedcba.
- dp  out  1  active-low decimal point.
- frame_tick  out  1  one-cycle pulse at each frame start.

Function
REQ-005 Prescaler cnt SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-006 Digit index idx SHALL advance when cnt wraps, stepping 0..NUM_DIGITS-1 and then wrapping to 0.
REQ-007 When idx wraps to 0, the block SHALL capture digits, msg, dp_mask, mode and synchronised bclk into shadow registers; all display decisions SHALL use the shadow values only, so a frame never tears.
REQ-008 The frame_tick output SHALL be high for exactly one cycle, in the cycle after the shadow capture.
REQ-009 bclk SHALL pass through a two-flop synchroniser before use.
REQ-010 All outputs SHALL be registered, one cycle after the cnt/idx values that produce them.
REQ-011 Ghost guard: while cnt==0, anode SHALL be all ones; while cnt is 1..SCAN_DIV-1, anode SHALL equal ~(1<<idx).
REQ-012 Number mode: nibbles 0-9 SHALL decode to the standard active-low patterns (0 = 1000000 … 9 = 0010000); nibbles 10-15 SHALL display dash 0111111.
REQ-013 Leading-zero suppression (BLANK_LEADING=1, number mode only): digit i>0 SHALL show blank 1111111 when nibble i and every higher nibble are 0; digit 0 SHALL never be blanked.
REQ-014 Message mode: segOut SHALL equal shadow msg slice idx.
REQ-015 Beat-alternate mode: the shadowed synchronised bclk SHALL select the source: 1 selects number-mode behaviour, 0 selects message-mode behaviour.
REQ-016 Blank mode: segOut SHALL be 1111111 and dp SHALL be 1; anodes SHALL still scan.
REQ-017 dp SHALL equal ~dp_mask[idx] in every mode except blank mode.
REQ-018 During the guard cycle (cnt==0), segOut SHALL be 1111111.
REQ-019 A mode change mid-frame SHALL take effect only at the next frame start.

Reset
REQ-020 While rst is high, and in the cycle after it releases, the block SHALL hold: cnt=0, idx=0, anode all ones, segOut=1111111, dp=1, frame_tick=0.
REQ-021 Shadows and synchroniser flops SHALL reset to 0.
REQ-022 The first frame_tick after reset SHALL occur only after one complete NUM_DIGITS*SCAN_DIV frame.
REQ-023 rst asserted mid-dwell SHALL force all outputs to their reset values asynchronously.

Structure
REQ-024 The shared package scan_disp_pkg SHALL hold the SEG_0..SEG_9, SEG_DASH and SEG_BLANK constants and the MODE_NUM, MODE_MSG, MODE_BEAT and MODE_BLANK encodings.
REQ-025 The purely combinational BCD-to-segment decode SHALL be a separate sub-module, seg7_decode (4-bit in, 7-bit out), reused by other display blocks.

Verification
REQ-026 NUM_DIGITS=4, SCAN_DIV=4, mode 0, digits=0x0120 -> per frame digit3 blank, digit2 1111001, digit1 0100100, digit0 1000000; each digit gets 1 guard cycle plus 3 active cycles; frame_tick period is 16 cycles.
REQ-027 digits=0x0000 with BLANK_LEADING=1 -> only digit 0 shows 1000000; the same stimulus with BLANK_LEADING=0 -> all four digits show 1000000.
REQ-028 Mode 2, msg="rEC-", bclk toggled every 3 frames -> the display switches between number and message only on frame boundaries; no frame mixes the two.
REQ-029 digits changes from 0x1234 to 0x5678 at idx=2 mid-frame -> the rest of that frame still shows 1234; the next frame shows 5678.
REQ-030 digits nibble=0xB, dp_mask=0001 -> that digit shows 0111111; dp=0 only while digit 0 is active.
REQ-031 rst pulsed during idx=1, cnt=2 -> outputs reach their reset values with no clock edge; after release, scanning restarts at idx=0 and the first frame_tick arrives exactly 16 cycles later.
